// File: rtl/tof_counter.sv
// tof_counter: counts cycles from start pulse to echoes and reports first/last echo, echo count or timeout.
module tof_counter #(
  parameter int CNT_W = 16,
  parameter int MAX_CNT = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_imp,
  input  logic             stop_imp,
  output logic             busy,
  output logic             overrun,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] first_cnt,
  output logic [CNT_W-1:0] last_cnt,
  output logic [2:0]       echo_num,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, BLANK, MEASURE, DONE} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_CNT);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic acc, fin;
  logic [2:0] num_n;
  // cnt holds the count that the next edge samples, so the start edge itself is count 0
  always_comb begin
    busy = state == BLANK || state == MEASURE;
    res_valid = state == DONE;
    cnt_n = cnt + ONE;
    acc = busy && stop_imp && cnt >= BLANK_LIM;
    fin = busy && cnt == MAX_LIM;
    num_n = acc ? echo_num + {2'b00, echo_num != 3'd7} : echo_num;
    state_n = state == IDLE ? (start_imp ? (BLANK_CYC > 1 ? BLANK : MEASURE) : IDLE)
            : busy ? (fin ? DONE : (cnt_n < BLANK_LIM ? BLANK : MEASURE))
            : (res_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      first_cnt <= '0;
      last_cnt <= '0;
      echo_num <= '0;
      timeout <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      overrun <= start_imp && state != IDLE;
      if (state == IDLE && start_imp) begin
        cnt <= ONE;
        first_cnt <= '0;
        last_cnt <= '0;
        echo_num <= '0;
        timeout <= 1'b0;
      end else if (busy) begin
        cnt <= fin ? cnt : cnt_n;
        if (acc && echo_num == 3'd0) first_cnt <= cnt;
        if (acc) last_cnt <= cnt;
        echo_num <= num_n;
        if (fin) timeout <= num_n == 3'd0;
      end
    end
  end
endmodule
